mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU memory bus (address/read/write/writedata/byteenable/readdata/waitrequest).
- Shares a single RAM/slave port between instruction fetch (m0) and data access (m1).
- Round-robin grant; grant is held for the whole transfer.
- A watchdog aborts transfers the slave never completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT, 255, maximum stalled cycles per transfer; 0 disables the watchdog

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_readdata  out  DATA_W  master 0 read data
- m0_waitrequest  out  1  master 0 stall
- m1_*  (same seven signals as m0_*)  master 1
- s_address  out  ADDR_W  to slave
- s_read  out  1  to slave
- s_write  out  1  to slave
- s_writedata  out  DATA_W  to slave
- s_byteenable  out  DATA_W/8  to slave
- s_readdata  in  DATA_W  from slave
- s_waitrequest  in  1  from slave
- grant  out  2  one-hot current owner; 00 when idle
- bus_error  out  1  sticky timeout flag

Behaviour:
- Request from master k: mk_read | mk_write. Masters hold all signals stable while mk_waitrequest=1. Read and write asserted together is illegal; write wins.
- Registered state: IDLE or BUSY, plus owner (1 bit), last_owner (1 bit), stall counter (clog2(TIMEOUT+1) bits).
- Reset values: state=IDLE, last_owner=1 (so m0 wins the first tie), counter=0, bus_error=0, grant=00.
- Reset output values: s_read=0, s_write=0, s_address/s_writedata/s_byteenable=0, m0_waitrequest=m1_waitrequest=1, m0_readdata=m1_readdata=0.
- IDLE:
  - One requester: owner<=that master.
  - Both requesting: owner<=!last_owner.
  - Any request: next state BUSY, counter<=0.
  - No request: stay IDLE.
  - Slave outputs are all 0 in IDLE.
- BUSY:
  - s_* signals combinationally mirror the owner's address, read, write, writedata and byteenable.
  - grant is one-hot of owner.
- Completion: BUSY & owner requesting & s_waitrequest=0.
  - Owner waitrequest=0 for that cycle.
  - Owner readdata=s_readdata in that cycle (zero latency; reads are valid when waitrequest is low).
  - Next cycle: last_owner<=owner, state<=IDLE.
- Minimum transfer is 2 cycles: 1 arbitration cycle + 1 transfer cycle.
- Non-owner at all times: waitrequest=1, readdata=0.
- Stall: BUSY & s_waitrequest=1 -> counter+1 each cycle.
- Timeout: TIMEOUT!=0 and counter==TIMEOUT (checked before increment):
  - Forced completion that cycle: s_read=s_write=0, owner waitrequest=0, owner readdata=0.
  - bus_error<=1, held until reset.
  - Next cycle: IDLE, last_owner<=owner.
- Owner drops its request in BUSY (protocol violation): s_read=s_write=0, next cycle IDLE, last_owner unchanged, no error flagged.
- Fairness:
  - Back-to-back requests from both masters alternate m0, m1, m0, ...
  - A lone requester is granted every second cycle.
- Reset asserted mid-transfer: next edge forces the reset state. The transfer is abandoned with no completion pulse; the master must reissue it.
- Writes: byteenable passes through unmodified. Lane/endian mapping belongs to the slave, not the arbiter.

Decomposition:
- Package mips_bus_pkg:
  - typedef arb_state_t {IDLE, BUSY}
  - localparams ADDR_W=32, DATA_W=32, BE_W=DATA_W/8
  - RESET_VECTOR=32'hBFC00000, for shared bench use
- One sub-module, mips_rr_pick: combinational 2-way round-robin selector.
  - Inputs: req[1:0], last_owner.
  - Outputs: pick, any.

Test Plan:
1. m0 read of 0xBFC00000; slave waitrequest=0, s_readdata=0x3C021234 -> grant=01 at cycle 1; m0_waitrequest=0 and m0_readdata=0x3C021234 at cycle 1; IDLE at cycle 2.
2. m0 read and m1 write (0xBFC00010, data 0xC0000000, be 4'b1111) issued together and held -> m0 served first, m1 next. s_write=1 with s_writedata=0xC0000000 on m1's transfer cycle. Three more rounds of both requesting alternate m0, m1, m0.
3. m1 write, be=4'b0011, slave waitrequest=1 for 3 cycles -> s_* stable for 4 BUSY cycles; m1_waitrequest=0 only on the 4th; s_byteenable=4'b0011 throughout.
4. TIMEOUT=4, slave waitrequest stuck at 1 -> forced completion on the 5th BUSY cycle; m0_readdata=0; bus_error=1, held 1 until reset.
5. Reset pulsed on the 2nd stalled cycle of an m1 transfer -> next cycle grant=00, s_read=s_write=0, both waitrequests=1, bus_error=0. With both masters then requesting, m0 is granted first.
6. m0 drops m0_read after 1 stalled cycle -> s_read=0 that cycle; IDLE next cycle; bus_error stays 0; pending m1 request granted next.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the CPU memory bus arbiter
package mips_bus_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
endpackage

// File: rtl/mips_rr_pick.sv
// mips_rr_pick: two-way round-robin selector favouring the master not served last
module mips_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       pick,
    output logic       any
);
    always_comb begin
        any = |req;
        pick = &req ? ~last_owner : req[1];
    end
endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin two-master to one-slave bus arbiter with stall watchdog
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_waitrequest,
    output logic [1:0]            grant,
    output logic                  bus_error
);
    import mips_bus_pkg::*;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    arb_state_t state, state_n;
    logic owner, owner_n, last_owner, last_owner_n, bus_error_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pick, any, busy, o_read, o_write, o_req, timeout, done;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_writedata;
    logic [DATA_W/8-1:0] o_byteenable;

    mips_rr_pick u_pick (
        .req({m1_read | m1_write, m0_read | m0_write}),
        .last_owner(last_owner),
        .pick(pick),
        .any(any)
    );

    always_comb begin
        busy = state == BUSY;
        o_address = owner ? m1_address : m0_address;
        o_read = owner ? m1_read : m0_read;
        o_write = owner ? m1_write : m0_write;
        o_writedata = owner ? m1_writedata : m0_writedata;
        o_byteenable = owner ? m1_byteenable : m0_byteenable;
        o_req = o_read | o_write;
        timeout = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
        // a watchdog expiry counts as completion so the master is released
        done = busy & o_req & (~s_waitrequest | timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last_owner <= 1'b1;
            cnt <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last_owner <= last_owner_n;
            cnt <= cnt_n;
            bus_error <= bus_error_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_owner_n = last_owner;
        cnt_n = cnt;
        bus_error_n = bus_error;
        if (!busy) begin
            if (any) begin
                state_n = BUSY;
                owner_n = pick;
                cnt_n = '0;
            end
        end else if (!o_req) begin
            state_n = IDLE;
        end else if (done) begin
            state_n = IDLE;
            last_owner_n = owner;
            bus_error_n = bus_error | timeout;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_comb begin
        s_address = busy ? o_address : '0;
        s_writedata = busy ? o_writedata : '0;
        s_byteenable = busy ? o_byteenable : '0;
        s_write = busy & o_write & ~timeout;
        s_read = busy & o_read & ~o_write & ~timeout;
        grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
        m0_waitrequest = ~(done & ~owner);
        m1_waitrequest = ~(done & owner);
        m0_readdata = (done & ~owner & ~timeout) ? s_readdata : '0;
        m1_readdata = (done & owner & ~timeout) ? s_readdata : '0;
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed scenarios plus randomized traffic against a transfer-level model
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;
    logic clk = 1'b0, reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic m0_read, m0_write, m1_read, m1_write, m0_waitrequest, m1_waitrequest;
    logic [3:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic s_read, s_write, s_waitrequest, bus_error;
    logic [1:0] grant;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .bus_error(bus_error)
    );

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        {m0_address, m0_read, m0_write, m0_writedata, m0_byteenable} = '0;
        {m1_address, m1_read, m1_write, m1_writedata, m1_byteenable} = '0;
        s_readdata = '0;
        s_waitrequest = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== '0) begin errors++; $display("FAIL reset_slave got=%b%b %h %h %h exp=0", s_read, s_write, s_address, s_writedata, s_byteenable); end
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL reset_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest}); end
        checks++; if ({m0_readdata, m1_readdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h %h exp=0", m0_readdata, m1_readdata); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus_error); end
    endtask

    task automatic test_single_read;
        do_reset();
        m0_address = RESET_VECTOR;
        m0_read = 1'b1;
        s_readdata = 32'h3C021234;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_c0_grant got=%b exp=00", grant); end
        nxt();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_c1_grant got=%b exp=01", grant); end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL single_c1_wait got=%b%b exp=01", m0_waitrequest, m1_waitrequest); end
        checks++; if (m0_readdata !== 32'h3C021234) begin errors++; $display("FAIL single_c1_rdata got=%h exp=3c021234", m0_readdata); end
        checks++; if (s_read !== 1'b1 || s_address !== RESET_VECTOR) begin errors++; $display("FAIL single_c1_slave got=%b %h exp=1 bfc00000", s_read, s_address); end
        nxt();
        m0_read = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_c2_grant got=%b exp=00", grant); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g;
        do_reset();
        m0_address = RESET_VECTOR;
        m0_read = 1'b1;
        m1_address = 32'hBFC00010;
        m1_writedata = 32'hC0000000;
        m1_byteenable = 4'b1111;
        m1_write = 1'b1;
        s_readdata = 32'h12345678;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL alt_grant cycle=%0d got=%b exp=%b", k, grant, exp_g); end
            if (exp_g == 2'b10) begin
                checks++; if ({s_write, s_read, s_address, s_writedata, s_byteenable} !== {2'b10, 32'hBFC00010, 32'hC0000000, 4'hF}) begin errors++; $display("FAIL alt_m1_write cycle=%0d got=%b%b %h %h %h exp=10 bfc00010 c0000000 f", k, s_write, s_read, s_address, s_writedata, s_byteenable); end
            end
            nxt();
        end
        idle_inputs();
    endtask

    task automatic test_stall;
        do_reset();
        m1_address = 32'h00001000;
        m1_writedata = 32'hDEADBEEF;
        m1_byteenable = 4'b0011;
        m1_write = 1'b1;
        s_waitrequest = 1'b1;
        nxt();
        for (int i = 1; i <= 4; i++) begin
            s_waitrequest = (i < 4);
            #1;
            checks++; if ({s_write, s_read, s_address, s_writedata, s_byteenable} !== {2'b10, 32'h00001000, 32'hDEADBEEF, 4'b0011}) begin errors++; $display("FAIL stall_slave busy=%0d got=%b%b %h %h %b", i, s_write, s_read, s_address, s_writedata, s_byteenable); end
            checks++; if (m1_waitrequest !== (i < 4)) begin errors++; $display("FAIL stall_wait busy=%0d got=%b exp=%b", i, m1_waitrequest, i < 4); end
            nxt();
        end
        m1_write = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_after_grant got=%b exp=00", grant); end
    endtask

    task automatic test_timeout;
        do_reset();
        m0_address = 32'h00000040;
        m0_read = 1'b1;
        s_waitrequest = 1'b1;
        s_readdata = 32'hFFFFFFFF;
        nxt();
        for (int i = 1; i <= 5; i++) begin
            #1;
            checks++; if (m0_waitrequest !== (i < 5)) begin errors++; $display("FAIL to_wait busy=%0d got=%b exp=%b", i, m0_waitrequest, i < 5); end
            checks++; if (s_read !== (i < 5)) begin errors++; $display("FAIL to_sread busy=%0d got=%b exp=%b", i, s_read, i < 5); end
            checks++; if (m0_readdata !== 32'h0) begin errors++; $display("FAIL to_rdata busy=%0d got=%h exp=0", i, m0_readdata); end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_err_early busy=%0d got=%b exp=0", i, bus_error); end
            nxt();
        end
        m0_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_err_sticky cycle=%0d got=%b exp=1", i, bus_error); end
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_idle cycle=%0d got=%b exp=00", i, grant); end
            nxt();
        end
        do_reset();
        #1;
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_err_cleared got=%b exp=0", bus_error); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        m1_address = 32'h00000080;
        m1_read = 1'b1;
        s_waitrequest = 1'b1;
        nxt();
        nxt();
        #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmid_busy_grant got=%b exp=10", grant); end
        reset = 1'b1;
        nxt();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant got=%b exp=00", grant); end
        checks++; if ({s_read, s_write} !== 2'b00) begin errors++; $display("FAIL rmid_rw got=%b exp=00", {s_read, s_write}); end
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL rmid_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest}); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", bus_error); end
        reset = 1'b0;
        m0_address = 32'h00000100;
        m0_read = 1'b1;
        nxt();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_first_grant got=%b exp=01", grant); end
        idle_inputs();
    endtask

    task automatic test_drop;
        do_reset();
        m0_address = 32'h00000200;
        m0_read = 1'b1;
        m1_address = 32'h00000300;
        m1_write = 1'b1;
        s_waitrequest = 1'b1;
        nxt();
        #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL drop_grant got=%b exp=01", grant); end
        nxt();
        m0_read = 1'b0;
        #1;
        checks++; if ({s_read, s_write} !== 2'b00) begin errors++; $display("FAIL drop_rw got=%b exp=00", {s_read, s_write}); end
        nxt();
        #1;
        checks++; if (grant !== 2'b00 || bus_error !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b err=%b exp=00 err=0", grant, bus_error); end
        nxt();
        s_waitrequest = 1'b0;
        #1;
        checks++; if (grant !== 2'b10 || s_write !== 1'b1) begin errors++; $display("FAIL drop_m1_grant got=%b w=%b exp=10 w=1", grant, s_write); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_random;
        int cur, last, stall, c;
        bit err, rq, to, fin;
        bit act[2];
        logic rd[2], wr[2];
        logic [31:0] ad[2], wd[2], exp_r[2];
        logic [3:0] be[2];
        logic [69:0] exp_s;
        logic [1:0] exp_g, exp_w;
        do_reset();
        cur = -1; last = 1; stall = 0; err = 1'b0;
        for (int k = 0; k < 2; k++) begin act[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0; be[k] = '0; end
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!act[k] && $urandom_range(2) == 0) begin
                    act[k] = 1'b1;
                    wr[k] = 1'($urandom_range(1));
                    rd[k] = ~wr[k];
                    ad[k] = $urandom;
                    wd[k] = $urandom;
                    be[k] = 4'($urandom);
                end else if (!act[k]) begin
                    rd[k] = 1'b0;
                    wr[k] = 1'b0;
                end
            end
            {m0_read, m0_write, m0_address, m0_writedata, m0_byteenable} = {rd[0], wr[0], ad[0], wd[0], be[0]};
            {m1_read, m1_write, m1_address, m1_writedata, m1_byteenable} = {rd[1], wr[1], ad[1], wd[1], be[1]};
            s_waitrequest = 1'($urandom_range(1));
            s_readdata = $urandom;
            #1;
            c = (cur < 0) ? 0 : cur;
            rq = (cur >= 0) && (rd[c] || wr[c]);
            to = (cur >= 0) && (stall == 4);
            fin = rq && (to || !s_waitrequest);
            exp_s = (cur < 0) ? '0 : {rq && !to && rd[c] && !wr[c], !to && wr[c], ad[c], wd[c], be[c]};
            exp_g = (cur < 0) ? 2'b00 : ((cur == 1) ? 2'b10 : 2'b01);
            exp_w = 2'b11;
            exp_r[0] = '0;
            exp_r[1] = '0;
            if (fin) begin
                exp_w[c] = 1'b0;
                exp_r[c] = to ? 32'h0 : s_readdata;
            end
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rnd_grant cycle=%0d got=%b exp=%b", n, grant, exp_g); end
            checks++; if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== exp_s) begin errors++; $display("FAIL rnd_slave cycle=%0d got=%h exp=%h", n, {s_read, s_write, s_address, s_writedata, s_byteenable}, exp_s); end
            checks++; if ({m0_waitrequest, m0_readdata} !== {exp_w[0], exp_r[0]}) begin errors++; $display("FAIL rnd_m0 cycle=%0d got=%b %h exp=%b %h", n, m0_waitrequest, m0_readdata, exp_w[0], exp_r[0]); end
            checks++; if ({m1_waitrequest, m1_readdata} !== {exp_w[1], exp_r[1]}) begin errors++; $display("FAIL rnd_m1 cycle=%0d got=%b %h exp=%b %h", n, m1_waitrequest, m1_readdata, exp_w[1], exp_r[1]); end
            checks++; if (bus_error !== err) begin errors++; $display("FAIL rnd_err cycle=%0d got=%b exp=%b", n, bus_error, err); end
            if (cur < 0) begin
                if (act[0] || act[1]) begin
                    cur = (act[0] && act[1]) ? 1 - last : (act[0] ? 0 : 1);
                    stall = 0;
                end
            end else if (!rq) begin
                cur = -1;
            end else if (fin) begin
                last = cur;
                err = err | to;
                act[c] = 1'b0;
                cur = -1;
            end else begin
                stall++;
            end
            nxt();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
